// File: rtl/siso_xfer_ctrl_if.sv
// siso_xfer_ctrl_if
//   Groups the request, serial and receive handshake signals of one
//   serial word transfer controller.
//   slave  : the controller side (accepts start requests, drives sdo and
//            presents rx_data).
//   master : the host/link side (issues requests, feeds sdi, consumes
//            rx_data).
//   Signals:
//     start_valid / start_ready / tx_data / dir : request handshake
//     abort                                     : cancel transfer in progress
//     sdo / sdi / bit_strobe                    : serial path
//     busy                                      : shifting in progress
//     rx_valid / rx_ready / rx_data             : receive handshake
interface siso_xfer_ctrl_if #(
  parameter int N = 4
);
  logic         start_valid;
  logic         start_ready;
  logic [N-1:0] tx_data;
  logic         dir;
  logic         abort;
  logic         sdo;
  logic         sdi;
  logic         bit_strobe;
  logic         busy;
  logic         rx_valid;
  logic         rx_ready;
  logic [N-1:0] rx_data;

  modport slave (
    input  start_valid, tx_data, dir, abort, sdi, rx_ready,
    output start_ready, sdo, bit_strobe, busy, rx_valid, rx_data
  );

  modport master (
    output start_valid, tx_data, dir, abort, sdi, rx_ready,
    input  start_ready, sdo, bit_strobe, busy, rx_valid, rx_data
  );
endinterface

// File: rtl/siso_xfer_ctrl.sv
// siso_xfer_ctrl
//   Sequences one serial word transfer: accepts a parallel word, shifts it
//   out on sdo at one bit per DIV clocks (MSB- or LSB-first), captures sdi
//   into a receive word in the same order and presents it with a
//   valid/ready handshake.
//   Ports:
//     clk  : rising-edge clock
//     rst  : synchronous active-high reset
//     bus  : siso_xfer_ctrl_if.slave (request, serial and receive signals)
//   Parameters:
//     N    : word width (>= 2)
//     DIV  : clocks per bit (>= 1)
module siso_xfer_ctrl #(
  parameter int N   = 4,
  parameter int DIV = 2
) (
  input  logic               clk,
  input  logic               rst,
  siso_xfer_ctrl_if.slave    bus
);

  // A one-clock-per-bit divider still needs a 1-bit counter that stays 0.
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CNT_W = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [N-1:0]       r_tx_sh;
  logic [N-1:0]       w_tx_sh_next;
  logic [N-1:0]       r_rx_sh;
  logic [N-1:0]       w_rx_sh_next;
  logic [N-1:0]       r_rx_data;
  logic [N-1:0]       w_rx_data_next;
  logic               r_dir;
  logic               w_dir_next;
  logic [DIV_W-1:0]   r_div_cnt;
  logic [DIV_W-1:0]   w_div_cnt_next;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic [CNT_W-1:0]   w_bit_cnt_next;

  logic               w_busy;
  logic               w_tick;
  logic               w_last;
  logic [N-1:0]       w_tx_shifted;
  logic [N-1:0]       w_rx_shifted;

  assign w_busy = (r_state == S_SHIFT);
  assign w_tick = (r_div_cnt == DIV_W'(DIV - 1));
  assign w_last = (r_bit_cnt == CNT_W'(N - 1));

  // Shift direction follows the direction latched at accept time, so the
  // transmit and receive words always share the same bit order.
  always_comb begin
    w_tx_shifted = r_tx_sh;
    w_rx_shifted = r_rx_sh;
    if (r_dir) begin
      w_tx_shifted = {1'b0, r_tx_sh[N-1:1]};
      w_rx_shifted = {bus.sdi, r_rx_sh[N-1:1]};
    end else begin
      w_tx_shifted = {r_tx_sh[N-2:0], 1'b0};
      w_rx_shifted = {r_rx_sh[N-2:0], bus.sdi};
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_tx_sh_next   = r_tx_sh;
    w_rx_sh_next   = r_rx_sh;
    w_rx_data_next = r_rx_data;
    w_dir_next     = r_dir;
    w_div_cnt_next = r_div_cnt;
    w_bit_cnt_next = r_bit_cnt;

    unique case (r_state)
      S_IDLE: begin
        if (bus.start_valid) begin
          w_state_next   = S_SHIFT;
          w_tx_sh_next   = bus.tx_data;
          w_dir_next     = bus.dir;
          w_div_cnt_next = '0;
          w_bit_cnt_next = '0;
          w_rx_sh_next   = '0;
        end
      end

      S_SHIFT: begin
        if (bus.abort) begin
          // Cancel without shifting or sampling in this cycle.
          w_state_next = S_IDLE;
        end else if (w_tick) begin
          w_div_cnt_next = '0;
          w_tx_sh_next   = w_tx_shifted;
          w_rx_sh_next   = w_rx_shifted;
          w_bit_cnt_next = r_bit_cnt + 1'b1;
          if (w_last) begin
            // Publish the word including the bit sampled on this tick.
            w_state_next   = S_DONE;
            w_rx_data_next = w_rx_shifted;
          end
        end else begin
          w_div_cnt_next = r_div_cnt + 1'b1;
        end
      end

      S_DONE: begin
        if (bus.rx_ready) begin
          w_state_next = S_IDLE;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_tx_sh   <= '0;
      r_rx_sh   <= '0;
      r_rx_data <= '0;
      r_dir     <= 1'b0;
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_tx_sh   <= w_tx_sh_next;
      r_rx_sh   <= w_rx_sh_next;
      r_rx_data <= w_rx_data_next;
      r_dir     <= w_dir_next;
      r_div_cnt <= w_div_cnt_next;
      r_bit_cnt <= w_bit_cnt_next;
    end
  end

  assign bus.start_ready = (r_state == S_IDLE);
  assign bus.busy        = w_busy;
  assign bus.rx_valid    = (r_state == S_DONE);
  assign bus.rx_data     = r_rx_data;
  // sdo comes from registers only so a loopback sdi cannot form a comb loop.
  assign bus.sdo         = w_busy ? (r_dir ? r_tx_sh[0] : r_tx_sh[N-1]) : 1'b0;
  // An aborted tick does not sample, so it does not strobe either.
  assign bus.bit_strobe  = w_busy && w_tick && !bus.abort;

endmodule
